// File: rtl/btn_pkg.sv
// -----------------------------------------------------------------------------
// btn_pkg
// Shared types and helpers for the button conditioner.
//   btn_state_t : per-channel debounce/hold FSM states
//   cnt_width   : counter width large enough for the biggest cycle count
// -----------------------------------------------------------------------------
package btn_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        HELD         = 2'd2,
        RELEASE_PEND = 2'd3
    } btn_state_t;

    // Width holding max(a, b, c) without wrapping; at least 1 bit.
    function automatic int cnt_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end
        if (c > m) begin
            m = c;
        end
        if (m < 1) begin
            m = 1;
        end
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/button_channel.sv
// -----------------------------------------------------------------------------
// button_channel
// One button: two-flop synchroniser, debounce FSM, optional auto-repeat.
// Ports:
//   clock, reset   : system clock, synchronous active-high reset
//   raw            : asynchronous button level, 1 = pressed
//   repeat_en      : 1 enables auto-repeat of the press pulse while held
//   level          : debounced level
//   press_pulse    : 1-cycle pulse on accepted press and on each repeat
//   release_pulse  : 1-cycle pulse on accepted release
//   held           : 1 while in HELD or RELEASE_PEND
// -----------------------------------------------------------------------------
module button_channel
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic held
);

    localparam int CW = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);

    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [CW-1:0] CNT_MAX    = {CW{1'b1}};
    localparam logic [CW-1:0] DEB_C      = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] RPT_DELAY  = CW'(REPEAT_DELAY);
    localparam logic [CW-1:0] RPT_PERIOD = CW'(REPEAT_PERIOD);

    logic          sync_meta_r;
    logic          sync_r;
    btn_state_t    state_r;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] rpt_cnt_r;
    logic          rpt_phase_r;   // 0: waiting for first repeat, 1: periodic
    logic          level_r;
    logic          press_r;
    logic          release_r;
    logic          held_r;
    logic [CW-1:0] cnt_inc_s;
    logic [CW-1:0] rpt_inc_s;

    // Saturating increments so the counters can never wrap.
    always_comb begin
        cnt_inc_s = cnt_r;
        rpt_inc_s = rpt_cnt_r;
        if (cnt_r != CNT_MAX) begin
            cnt_inc_s = cnt_r + CNT_ONE;
        end else begin
            cnt_inc_s = cnt_r;
        end
        if (rpt_cnt_r != CNT_MAX) begin
            rpt_inc_s = rpt_cnt_r + CNT_ONE;
        end else begin
            rpt_inc_s = rpt_cnt_r;
        end
    end

    // Two-flop synchroniser for the asynchronous raw level.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_meta_r <= 1'b0;
            sync_r      <= 1'b0;
        end else begin
            sync_meta_r <= raw;
            sync_r      <= sync_meta_r;
        end
    end

    // Debounce/hold FSM with registered level, pulse and held outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= RELEASED;
            cnt_r       <= CNT_ZERO;
            rpt_cnt_r   <= CNT_ZERO;
            rpt_phase_r <= 1'b0;
            level_r     <= 1'b0;
            press_r     <= 1'b0;
            release_r   <= 1'b0;
            held_r      <= 1'b0;
        end else begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
            case (state_r)
                RELEASED: begin
                    rpt_cnt_r   <= CNT_ZERO;
                    rpt_phase_r <= 1'b0;
                    held_r      <= 1'b0;
                    level_r     <= 1'b0;
                    if (sync_r) begin
                        state_r <= PRESS_PEND;
                        cnt_r   <= CNT_ONE;
                    end else begin
                        cnt_r   <= CNT_ZERO;
                    end
                end
                PRESS_PEND: begin
                    if (!sync_r) begin
                        // Glitch shorter than the debounce window: drop it silently.
                        state_r <= RELEASED;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == DEB_C) begin
                        state_r     <= HELD;
                        cnt_r       <= CNT_ZERO;
                        level_r     <= 1'b1;
                        press_r     <= 1'b1;
                        held_r      <= 1'b1;
                        rpt_cnt_r   <= CNT_ZERO;
                        rpt_phase_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                HELD: begin
                    if (!sync_r) begin
                        state_r     <= RELEASE_PEND;
                        cnt_r       <= CNT_ONE;
                        rpt_cnt_r   <= CNT_ZERO;
                        rpt_phase_r <= 1'b0;
                    end else if (repeat_en) begin
                        // rpt_inc_s is the number of cycles since HELD entry
                        // (or since the previous repeat pulse).
                        if (!rpt_phase_r && (rpt_inc_s == RPT_DELAY)) begin
                            press_r     <= 1'b1;
                            rpt_cnt_r   <= CNT_ZERO;
                            rpt_phase_r <= 1'b1;
                        end else if (rpt_phase_r && (rpt_inc_s == RPT_PERIOD)) begin
                            press_r   <= 1'b1;
                            rpt_cnt_r <= CNT_ZERO;
                        end else begin
                            rpt_cnt_r <= rpt_inc_s;
                        end
                    end else begin
                        rpt_cnt_r <= CNT_ZERO;
                    end
                end
                RELEASE_PEND: begin
                    if (sync_r) begin
                        // Release bounce: back to HELD, repeat timing restarts.
                        state_r     <= HELD;
                        cnt_r       <= CNT_ZERO;
                        rpt_cnt_r   <= CNT_ZERO;
                        rpt_phase_r <= 1'b0;
                    end else if (cnt_r == DEB_C) begin
                        state_r   <= RELEASED;
                        cnt_r     <= CNT_ZERO;
                        level_r   <= 1'b0;
                        release_r <= 1'b1;
                        held_r    <= 1'b0;
                    end else begin
                        cnt_r <= cnt_inc_s;
                    end
                end
                default: begin
                    state_r     <= RELEASED;
                    cnt_r       <= CNT_ZERO;
                    rpt_cnt_r   <= CNT_ZERO;
                    rpt_phase_r <= 1'b0;
                    level_r     <= 1'b0;
                    held_r      <= 1'b0;
                end
            endcase
        end
    end

    assign level         = level_r;
    assign press_pulse   = press_r;
    assign release_pulse = release_r;
    assign held          = held_r;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions NUM_BTN raw board buttons into debounced levels and single-cycle
// press/release pulses. btn_press[0] drives Next, btn_press[1] drives Done.
// Ports:
//   clock        : system clock
//   reset        : synchronous active-high reset
//   btn_raw      : raw asynchronous button levels, 1 = pressed
//   btn_level    : debounced levels
//   btn_press    : 1-cycle pulse per accepted press and per auto-repeat
//   btn_release  : 1-cycle pulse per accepted release
//   btn_held     : 1 while a channel is held or pending release
// -----------------------------------------------------------------------------
module button_conditioner
    import btn_pkg::*;
#(
    parameter int                 NUM_BTN         = 5,
    parameter int                 DEBOUNCE_CYCLES = 1000000,
    parameter logic [NUM_BTN-1:0] REPEAT_EN       = {NUM_BTN{1'b0}},
    parameter int                 REPEAT_DELAY    = 50000000,
    parameter int                 REPEAT_PERIOD   = 10000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic [NUM_BTN-1:0] btn_release,
    output logic [NUM_BTN-1:0] btn_held
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_chan (
            .clock         (clock),
            .reset         (reset),
            .raw           (btn_raw[g]),
            .repeat_en     (REPEAT_EN[g]),
            .level         (btn_level[g]),
            .press_pulse   (btn_press[g]),
            .release_pulse (btn_release[g]),
            .held          (btn_held[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed testbench for button_conditioner with DEBOUNCE_CYCLES = 4,
// REPEAT_DELAY = 10, REPEAT_PERIOD = 5, NUM_BTN = 2, REPEAT_EN = 2'b10.
// Inputs change just after a falling edge; outputs are sampled on falling
// edges. A raw change driven before observation tick 1 shows up at tick 7.
module tb_button_conditioner;

    logic       clock;
    logic       reset;
    logic [1:0] btn_raw;
    logic [1:0] btn_level;
    logic [1:0] btn_press;
    logic [1:0] btn_release;
    logic [1:0] btn_held;

    int checks = 0;
    int errors = 0;

    button_conditioner #(
        .NUM_BTN         (2),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (2'b10),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (5)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_held    (btn_held)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Observed vector order: {level, press, release, held}
    task automatic test_reset();
        logic [7:0] exp;
        reset   = 1'b1;
        btn_raw = 2'b00;
        @(negedge clock);
        @(negedge clock);
        exp = 8'h00;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_held} !== exp) begin
            errors++;
            $display("FAIL reset_state got %b exp %b", {btn_level, btn_press, btn_release, btn_held}, exp);
        end
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if ({btn_level, btn_press, btn_release, btn_held} !== exp) begin
            errors++;
            $display("FAIL after_reset got %b exp %b", {btn_level, btn_press, btn_release, btn_held}, exp);
        end
    endtask

    task automatic test_clean_press();
        logic [7:0] exp;
        for (int t = 1; t <= 10; t++) begin
            btn_raw = 2'b01;
            @(negedge clock);
            exp = {(t >= 7) ? 2'b01 : 2'b00, (t == 7) ? 2'b01 : 2'b00, 2'b00, (t >= 7) ? 2'b01 : 2'b00};
            checks++;
            if ({btn_level, btn_press, btn_release, btn_held} !== exp) begin
                errors++;
                $display("FAIL clean_press t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release, btn_held}, exp);
            end
        end
        for (int t = 1; t <= 10; t++) begin
            btn_raw = 2'b00;
            @(negedge clock);
            exp = {(t < 7) ? 2'b01 : 2'b00, 2'b00, (t == 7) ? 2'b01 : 2'b00, (t < 7) ? 2'b01 : 2'b00};
            checks++;
            if ({btn_level, btn_press, btn_release, btn_held} !== exp) begin
                errors++;
                $display("FAIL clean_release t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release, btn_held}, exp);
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] exp;
        exp = 8'h00;
        for (int t = 1; t <= 12; t++) begin
            btn_raw = (t <= 3) ? 2'b01 : 2'b00;
            @(negedge clock);
            checks++;
            if ({btn_level, btn_press, btn_release, btn_held} !== exp) begin
                errors++;
                $display("FAIL glitch t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release, btn_held}, exp);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [7:0] exp;
        // Get channel 0 into HELD first.
        for (int t = 1; t <= 9; t++) begin
            btn_raw = 2'b01;
            @(negedge clock);
            if (t == 7) begin
                checks++;
                if (btn_press !== 2'b01) begin
                    errors++;
                    $display("FAIL bounce_setup_press got %b exp %b", btn_press, 2'b01);
                end
            end
        end
        // Bounce 0,0,1,1,0,0,1,1 then stay low from tick 9; release at tick 15.
        for (int t = 1; t <= 20; t++) begin
            btn_raw = (t == 3 || t == 4 || t == 7 || t == 8) ? 2'b01 : 2'b00;
            @(negedge clock);
            exp = {(t < 15) ? 2'b01 : 2'b00, 2'b00, (t == 15) ? 2'b01 : 2'b00, (t < 15) ? 2'b01 : 2'b00};
            checks++;
            if ({btn_level, btn_press, btn_release, btn_held} !== exp) begin
                errors++;
                $display("FAIL release_bounce t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release, btn_held}, exp);
            end
        end
    endtask

    task automatic test_repeat_simultaneous();
        logic [7:0] exp;
        logic [1:0] ep;
        logic [1:0] el;
        for (int t = 1; t <= 45; t++) begin
            btn_raw = (t <= 33) ? 2'b11 : 2'b00;
            @(negedge clock);
            ep = 2'b00;
            if (t == 7) begin
                ep = 2'b11;
            end else if (t == 17 || t == 22 || t == 27 || t == 32) begin
                ep = 2'b10;
            end
            el  = (t >= 7 && t <= 39) ? 2'b11 : 2'b00;
            exp = {el, ep, (t == 40) ? 2'b11 : 2'b00, el};
            checks++;
            if ({btn_level, btn_press, btn_release, btn_held} !== exp) begin
                errors++;
                $display("FAIL repeat_simul t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release, btn_held}, exp);
            end
        end
    endtask

    task automatic test_reset_held();
        logic [7:0] exp;
        btn_raw = 2'b01;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clock);
            if (t == 7) begin
                checks++;
                if (btn_press !== 2'b01) begin
                    errors++;
                    $display("FAIL reset_held_setup got %b exp %b", btn_press, 2'b01);
                end
            end
        end
        reset = 1'b1;
        @(negedge clock);
        exp = 8'h00;
        checks++;
        if ({btn_level, btn_press, btn_release, btn_held} !== exp) begin
            errors++;
            $display("FAIL reset_while_held got %b exp %b", {btn_level, btn_press, btn_release, btn_held}, exp);
        end
        reset = 1'b0;
        // Button still held: fresh press 7 ticks after reset deasserts.
        for (int t = 1; t <= 10; t++) begin
            @(negedge clock);
            exp = {(t >= 7) ? 2'b01 : 2'b00, (t == 7) ? 2'b01 : 2'b00, 2'b00, (t >= 7) ? 2'b01 : 2'b00};
            checks++;
            if ({btn_level, btn_press, btn_release, btn_held} !== exp) begin
                errors++;
                $display("FAIL repress_after_reset t=%0d got %b exp %b", t, {btn_level, btn_press, btn_release, btn_held}, exp);
            end
        end
        btn_raw = 2'b00;
        for (int t = 1; t <= 10; t++) begin
            @(negedge clock);
        end
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 2'b00;
        test_reset();
        test_clean_press();
        test_glitch();
        test_release_bounce();
        test_repeat_simultaneous();
        test_reset_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
